// File: rtl/test_result_collector_if.sv
// test_result_collector_if
//   Bundles the run-control and result signals between the test result
//   collector and its environment (per-unit CPU harnesses plus controller).
//   Parameter NUM_TESTS sets the number of harness done/pass pairs.
//   Modports:
//     master : environment side; drives go, test_done, dut_passed and
//              observes the collector results.
//     slave  : collector side; the mirror image of master.
//   Signals:
//     go           run request (rising edge launches a run)
//     test_done    per-harness completion flags
//     dut_passed   per-harness pass flags
//     start_tests  common start level to all harnesses
//     busy         run in progress
//     all_done     run finished, results valid
//     all_pass     no failures and no timeouts
//     fail_mask    harnesses that reported a failure
//     timeout_mask harnesses that never completed
//     fail_count   popcount(fail_mask | timeout_mask)
//     first_fail   lowest failing index
//     protocol_err sticky harness handshake violation flag
interface test_result_collector_if #(
  parameter int NUM_TESTS = 11
);
  localparam int CNT_OUT_W = $clog2(NUM_TESTS + 1);
  localparam int IDX_W     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;

  logic                 go;
  logic [NUM_TESTS-1:0] test_done;
  logic [NUM_TESTS-1:0] dut_passed;
  logic                 start_tests;
  logic                 busy;
  logic                 all_done;
  logic                 all_pass;
  logic [NUM_TESTS-1:0] fail_mask;
  logic [NUM_TESTS-1:0] timeout_mask;
  logic [CNT_OUT_W-1:0] fail_count;
  logic [IDX_W-1:0]     first_fail;
  logic                 protocol_err;

  modport master (
    output go, test_done, dut_passed,
    input  start_tests, busy, all_done, all_pass, fail_mask, timeout_mask,
           fail_count, first_fail, protocol_err
  );

  modport slave (
    input  go, test_done, dut_passed,
    output start_tests, busy, all_done, all_pass, fail_mask, timeout_mask,
           fail_count, first_fail, protocol_err
  );
endinterface

// File: rtl/test_result_collector.sv
// test_result_collector
//   Sequencer/scoreboard for the single-cycle CPU unit harnesses. A rising
//   edge on go launches a run: start_tests is raised, each harness's first
//   test_done rising edge is captured together with its dut_passed flag, and
//   the run ends either when every harness has completed or after
//   TIMEOUT_CYCLES wait cycles. Results are registered and held in DONE.
//   Parameters:
//     NUM_TESTS      number of harness done/pass pairs
//     TIMEOUT_CYCLES wait cycles before outstanding tests time out (>= 2)
//     CNT_W          wait counter width (must hold TIMEOUT_CYCLES)
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high reset
//     io     test_result_collector_if.slave (go, test_done, dut_passed in;
//            start_tests, busy, all_done, all_pass, fail_mask,
//            timeout_mask, fail_count, first_fail, protocol_err out)
//   Build option:
//     RESULT_COLLECTOR_PROTOCOL_CHECK_EN  when defined, builds the sticky
//     harness handshake checker driving protocol_err; otherwise it is 0.
module test_result_collector #(
  parameter int NUM_TESTS      = 11,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  test_result_collector_if.slave  io
);
  localparam int CNT_OUT_W = $clog2(NUM_TESTS + 1);
  localparam int IDX_W     = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    DONE
  } state_t;

  state_t state, stateNext;

  logic                 goPrev;
  logic [NUM_TESTS-1:0] donePrev;
  logic [NUM_TESTS-1:0] doneMask;
  logic [NUM_TESTS-1:0] failMask;
  logic [NUM_TESTS-1:0] timeoutMask;
  logic [CNT_W-1:0]     waitCnt;
  logic                 startTests;
  logic                 allPass;
  logic [CNT_OUT_W-1:0] failCount;
  logic [IDX_W-1:0]     firstFail;

  logic                 goRise;
  logic                 timeoutHit;
  logic                 finishAll;
  logic [NUM_TESTS-1:0] capture;
  logic [NUM_TESTS-1:0] doneNext;
  logic [NUM_TESTS-1:0] failNext;
  logic [NUM_TESTS-1:0] timeoutNext;
  logic [NUM_TESTS-1:0] badNext;
  logic [CNT_OUT_W-1:0] badCount;
  logic [IDX_W-1:0]     badFirst;

  assign goRise     = io.go & ~goPrev;
  assign timeoutHit = (waitCnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Capture and the end-of-run summary are computed from the masks as they
  // will be after this edge, so a harness finishing in the final wait cycle
  // is counted as completed rather than timed out.
  always_comb begin
    capture     = '0;
    badCount    = '0;
    badFirst    = '0;
    if (state == WAIT) begin
      capture = io.test_done & ~donePrev & ~doneMask;
    end
    doneNext    = doneMask | capture;
    failNext    = (failMask & ~capture) | (capture & ~io.dut_passed);
    finishAll   = &doneNext;
    timeoutNext = finishAll ? '0 : ~doneNext;
    badNext     = failNext | timeoutNext;
    for (int unsigned i = 0; i < NUM_TESTS; i++) begin
      badCount = badCount + CNT_OUT_W'(badNext[i]);
    end
    for (int unsigned i = NUM_TESTS; i > 0; i--) begin
      if (badNext[i-1]) begin
        badFirst = IDX_W'(i - 1);
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (goRise) stateNext = LAUNCH;
      LAUNCH:  stateNext = WAIT;
      WAIT:    if (finishAll || timeoutHit) stateNext = DONE;
      DONE:    if (goRise) stateNext = LAUNCH;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      goPrev      <= 1'b0;
      donePrev    <= '0;
      doneMask    <= '0;
      failMask    <= '0;
      timeoutMask <= '0;
      waitCnt     <= '0;
      startTests  <= 1'b0;
      allPass     <= 1'b0;
      failCount   <= '0;
      firstFail   <= '0;
    end else begin
      goPrev <= io.go;
      // Cleared on launch so a test_done already high in the first wait
      // cycle is seen as a rising edge.
      donePrev <= (state == LAUNCH) ? '0 : io.test_done;
      case (state)
        LAUNCH: begin
          doneMask    <= '0;
          failMask    <= '0;
          timeoutMask <= '0;
          waitCnt     <= '0;
          startTests  <= 1'b1;
          allPass     <= 1'b0;
          failCount   <= '0;
          firstFail   <= '0;
        end
        WAIT: begin
          doneMask <= doneNext;
          failMask <= failNext;
          waitCnt  <= waitCnt + CNT_W'(1);
          if (stateNext == DONE) begin
            timeoutMask <= timeoutNext;
            startTests  <= 1'b0;
            allPass     <= (badNext == '0);
            failCount   <= badCount;
            firstFail   <= badFirst;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.start_tests  = startTests;
  assign io.busy         = (state == LAUNCH) || (state == WAIT);
  assign io.all_done     = (state == DONE);
  assign io.all_pass     = allPass;
  assign io.fail_mask    = failMask;
  assign io.timeout_mask = timeoutMask;
  assign io.fail_count   = failCount;
  assign io.first_fail   = firstFail;

`ifdef RESULT_COLLECTOR_PROTOCOL_CHECK_EN
  logic [NUM_TESTS-1:0] passPrev;
  logic [NUM_TESTS-1:0] doneRise;
  logic [NUM_TESTS-1:0] doneFall;
  logic [NUM_TESTS-1:0] passFlip;
  logic                 protoHit;
  logic                 protocolErr;

  always_comb begin
    doneRise = io.test_done & ~donePrev;
    doneFall = ~io.test_done & donePrev;
    // Pass flag moving while done stays high on an already captured test.
    passFlip = io.test_done & donePrev & doneMask & (io.dut_passed ^ passPrev);
    protoHit = 1'b0;
    case (state)
      IDLE:    protoHit = |doneRise;
      WAIT:    protoHit = |(doneFall & doneMask) | |passFlip;
      DONE:    protoHit = |doneRise | |passFlip;
      default: protoHit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      passPrev    <= '0;
      protocolErr <= 1'b0;
    end else begin
      passPrev <= io.dut_passed;
      if (state == LAUNCH) begin
        protocolErr <= 1'b0;
      end else if (protoHit) begin
        protocolErr <= 1'b1;
      end
    end
  end

  assign io.protocol_err = protocolErr;
`else
  assign io.protocol_err = 1'b0;
`endif
endmodule

// File: tb/tb_test_result_collector.sv
module tb_test_result_collector;
  localparam int NT = 4;
  localparam int TO = 20;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  test_result_collector_if #(.NUM_TESTS(NT)) io ();

  test_result_collector #(
    .NUM_TESTS     (NT),
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io)
  );

  typedef struct {
    logic       allPass;
    logic [3:0] failMask;
    logic [3:0] timeoutMask;
    logic [2:0] failCount;
    logic [1:0] firstFail;
    int         waitCycles;
  } exp_t;

  exp_t expQ[$];
  int   nVec  = 0;
  int   nMiss = 0;

`ifdef RESULT_COLLECTOR_PROTOCOL_CHECK_EN
  localparam logic STICKY_PERR = 1'b1;
`else
  localparam logic STICKY_PERR = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, ".busy"},         32'(io.busy),         32'd0);
    check({tag, ".start_tests"},  32'(io.start_tests),  32'd0);
    check({tag, ".all_done"},     32'(io.all_done),     32'd0);
    check({tag, ".all_pass"},     32'(io.all_pass),     32'd0);
    check({tag, ".fail_mask"},    32'(io.fail_mask),    32'd0);
    check({tag, ".timeout_mask"}, 32'(io.timeout_mask), 32'd0);
    check({tag, ".fail_count"},   32'(io.fail_count),   32'd0);
    check({tag, ".first_fail"},   32'(io.first_fail),   32'd0);
    check({tag, ".protocol_err"}, 32'(io.protocol_err), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Produces a go rising edge and leaves the caller just after the edge that
  // enters the first wait cycle.
  task automatic launch();
    tick();
    io.go = 1'b0;
    tick();
    io.go = 1'b1;
    tick();
    tick();
  endtask

  task automatic pushExp(input logic ap, input logic [3:0] fm, input logic [3:0] tm,
                         input logic [2:0] fc, input logic [1:0] ff, input int wc);
    exp_t e;
    e.allPass     = ap;
    e.failMask    = fm;
    e.timeoutMask = tm;
    e.failCount   = fc;
    e.firstFail   = ff;
    e.waitCycles  = wc;
    expQ.push_back(e);
  endtask

  // cN: wait cycle in which test N's done rises (-1 = never).
  task automatic runTest(input string tag, input int c0, input int c1, input int c2, input int c3,
                         input logic [3:0] pass,
                         input logic ap, input logic [3:0] fm, input logic [3:0] tm,
                         input logic [2:0] fc, input logic [1:0] ff, input int wc);
    int cyc[4];
    cyc = '{c0, c1, c2, c3};
    pushExp(ap, fm, tm, fc, ff, wc);
    launch();
    check({tag, ".launch_busy"},  32'(io.busy),         32'd1);
    check({tag, ".launch_start"}, 32'(io.start_tests),  32'd1);
    check({tag, ".launch_masks"}, 32'({io.fail_mask, io.timeout_mask}), 32'd0);
    for (int c = 0; c < 25; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (cyc[i] == c) begin
          io.test_done[i]  = 1'b1;
          io.dut_passed[i] = pass[i];
        end
      end
      tick();
    end
    check({tag, ".done_reached"}, 32'(io.all_done), 32'd1);
    io.test_done  = '0;
    io.dut_passed = '0;
  endtask

  task automatic monitor();
    logic prevDone  = 1'b0;
    logic prevStart = 1'b0;
    int   waitCnt   = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (io.start_tests && !prevStart) waitCnt = 0;
      if (io.start_tests) waitCnt++;
      prevStart = io.start_tests;
      if (io.all_done && !prevDone) begin
        if (expQ.size() == 0) begin
          nVec++;
          nMiss++;
          $display("FAIL unexpected_done: got all_done=1 expected no completion at %0t", $time);
        end else begin
          e = expQ.pop_front();
          check("sb.all_pass",     32'(io.all_pass),     32'(e.allPass));
          check("sb.fail_mask",    32'(io.fail_mask),    32'(e.failMask));
          check("sb.timeout_mask", 32'(io.timeout_mask), 32'(e.timeoutMask));
          check("sb.fail_count",   32'(io.fail_count),   32'(e.failCount));
          check("sb.first_fail",   32'(io.first_fail),   32'(e.firstFail));
          check("sb.start_tests",  32'(io.start_tests),  32'd0);
          check("sb.wait_cycles",  32'(waitCnt),         32'(e.waitCycles));
        end
      end
      prevDone = io.all_done;
    end
  endtask

  task automatic stimulus();
    reset         = 1'b1;
    io.go         = 1'b0;
    io.test_done  = '0;
    io.dut_passed = '0;
    repeat (3) tick();
    checkAllZero("reset");
    reset = 1'b0;

    // All pass, dones at wait cycles 3,5,5,9.
    runTest("allpass", 3, 5, 5, 9, 4'b1111, 1'b1, 4'b0000, 4'b0000, 3'd0, 2'd0, 10);
    check("allpass.protocol_err", 32'(io.protocol_err), 32'd0);

    // Single failure on test 2.
    runTest("onefail", 2, 4, 6, 8, 4'b1011, 1'b0, 4'b0100, 4'b0000, 3'd1, 2'd2, 9);

    // go held high in DONE must not relaunch; results stay put.
    for (int k = 0; k < 4; k++) begin
      tick();
      check("gohold.all_done",  32'(io.all_done),  32'd1);
      check("gohold.busy",      32'(io.busy),      32'd0);
      check("gohold.fail_mask", 32'(io.fail_mask), 32'h4);
    end

    // Timeout on tests 2 and 3.
    runTest("timeout", 1, 4, -1, -1, 4'b0011, 1'b0, 4'b0000, 4'b1100, 3'd2, 2'd2, 20);
    // Last completion lands in the final wait cycle.
    runTest("boundary", 0, 7, 12, 19, 4'b1111, 1'b1, 4'b0000, 4'b0000, 3'd0, 2'd0, 20);
    // Everything already done in the first wait cycle.
    runTest("immediate", 0, 0, 0, 0, 4'b1111, 1'b1, 4'b0000, 4'b0000, 3'd0, 2'd0, 1);
    // Fail on test 0 plus timeout on test 3.
    runTest("mixed", 5, 6, 7, -1, 4'b1110, 1'b0, 4'b0001, 4'b1000, 3'd2, 2'd0, 20);

    // Reset in the middle of a wait after two captures.
    launch();
    io.test_done[0] = 1'b1; io.dut_passed[0] = 1'b0;
    tick();
    io.test_done[1] = 1'b1; io.dut_passed[1] = 1'b1;
    tick();
    tick();
    tick();
    check("midreset.busy_before", 32'(io.busy), 32'd1);
    reset         = 1'b1;
    io.go         = 1'b0;
    io.test_done  = '0;
    io.dut_passed = '0;
    tick();
    checkAllZero("midreset");
    reset = 1'b0;

    // Clean run after reset: test 0 never completes.
    runTest("postreset", -1, 3, 4, 5, 4'b1110, 1'b0, 4'b0000, 4'b0001, 3'd1, 2'd0, 20);

    // Sticky first result: test 0 pulses twice, second pulse reports a fail.
    pushExp(1'b1, 4'b0000, 4'b0000, 3'd0, 2'd0, 7);
    launch();
    for (int c = 0; c < 25; c++) begin
      case (c)
        1: begin io.test_done[0] = 1'b1; io.dut_passed[0] = 1'b1; end
        2: io.test_done[0] = 1'b0;
        3: begin io.test_done[0] = 1'b1; io.dut_passed[0] = 1'b0; end
        6: begin io.test_done[3:1] = 3'b111; io.dut_passed[3:1] = 3'b111; end
        default: ;
      endcase
      tick();
    end
    check("sticky.done_reached",  32'(io.all_done),     32'd1);
    check("sticky.fail_mask0",    32'(io.fail_mask[0]), 32'd0);
    check("sticky.protocol_err",  32'(io.protocol_err), 32'(STICKY_PERR));
    io.test_done  = '0;
    io.dut_passed = '0;

    // Relaunch clears the sticky protocol flag.
    runTest("final", 4, 3, 2, 1, 4'b0111, 1'b0, 4'b1000, 4'b0000, 3'd1, 2'd3, 5);
    check("final.protocol_err", 32'(io.protocol_err), 32'd0);

    tick();
    check("scoreboard_drained", 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end
endmodule

// File: doc/test_result_collector.md
Name: test_result_collector

Overview:
- Synthesizable sequencer/scoreboard that sits directly upstream and downstream of the per-unit test harnesses of the single-cycle CPU (data memory, register file, decoder, muxes, PC, RA, ALU, shift, concatenate, sign extend).
- Drives the common start_tests level and collects each harness's test_done/dut_passed pair.
- Enforces a cycle timeout and produces a registered pass/fail summary.
- Replaces free-running fixed-delay result checking with a deterministic FSM, so results are valid on a known cycle.

Parameters:
- NUM_TESTS, 11, number of harness done/pass pairs monitored.
- TIMEOUT_CYCLES, 1000, maximum WAIT cycles before outstanding tests are declared timed out (must be >= 2).
- CNT_W, 16, width of internal cycle counter (must hold TIMEOUT_CYCLES).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- go  input  1  run request; rising edge launches a run.
- test_done  input  NUM_TESTS  per-harness completion; rising edge marks completion.
- dut_passed  input  NUM_TESTS  per-harness pass flag; sampled on the test_done capture cycle.
- start_tests  output  1  common start level to all harnesses.
- busy  output  1  high in LAUNCH and WAIT.
- all_done  output  1  high in DONE.
- all_pass  output  1  valid when all_done; 1 iff no failures and no timeouts.
- fail_mask  output  NUM_TESTS  bit i=1: harness i reported dut_passed=0.
- timeout_mask  output  NUM_TESTS  bit i=1: harness i never completed.
- fail_count  output  $clog2(NUM_TESTS+1)  popcount(fail_mask|timeout_mask).
- first_fail  output  $clog2(NUM_TESTS)  lowest failing index; 0 when fail_count=0.
- protocol_err  output  1  see Optional Feature.

Behaviour:
- Clock and reset are decided: single clock clk; reset is synchronous and active-high.
- Reset, and reset at any point mid-run, takes effect at the next edge:
  - state=IDLE.
  - All outputs, masks and counters = 0.
  - go_prev=0 and done_prev=0.
- go edge detect: go_rise = go & ~go_prev, with go_prev registered every cycle.
- States:
  - IDLE: go_rise -> LAUNCH.
  - LAUNCH (1 cycle): clear fail_mask, timeout_mask, done_mask, done_prev and counter; set start_tests=1 (registered, visible from the first WAIT cycle); -> WAIT.
  - WAIT: start_tests held 1.
    - capture[i] = test_done[i] & ~done_prev[i] & ~done_mask[i].
    - On capture: done_mask[i]<=1 and fail_mask[i]<=~dut_passed[i].
    - done_prev is cleared in LAUNCH, so a test_done already high on the first WAIT cycle counts as completion.
    - Counter increments each WAIT cycle.
    - If (done_mask|capture) is all ones -> DONE.
    - Else if counter==TIMEOUT_CYCLES-1 -> timeout_mask <= ~(done_mask|capture), then DONE.
    - A capture in the same cycle as the timeout counts as completion, not timeout.
  - DONE: start_tests=0, all_done=1; results held stable. go_rise -> LAUNCH (re-run); a go held high from the previous launch does not retrigger.
- A second rising edge of an already-captured test_done is ignored; the first result is sticky.
- all_pass, fail_count and first_fail are registered and update on the DONE-entry edge.
- Latency: go rise at edge N gives start_tests high after edge N+2. A test whose done rises in WAIT cycle k has all_done asserted after the following edge, if it was the last to complete.

Optional Feature:
- Macro: RESULT_COLLECTOR_PROTOCOL_CHECK_EN.
- When defined, protocol_err is set sticky (cleared only by reset or LAUNCH) if any of these occur:
  - test_done[i] rises while state is IDLE or DONE.
  - test_done[i] falls in WAIT after capture.
  - dut_passed[i] changes while test_done[i] stays high after capture.
- protocol_err does not alter the masks.
- When undefined, protocol_err is tied 0 and no checking logic is built.

Test Plan (NUM_TESTS=4, TIMEOUT_CYCLES=20):
- All pass: go rises; test_done bits rise at WAIT cycles 3,5,5,9 with dut_passed=1 -> all_done on the edge after cycle 9; all_pass=1, fail_mask=0, fail_count=0, start_tests=0 in DONE.
- Single fail: test 2 done with dut_passed=0, others pass -> fail_mask=4'b0100, all_pass=0, fail_count=1, first_fail=2.
- Timeout: tests 0,1 complete and pass; 2,3 never complete -> DONE after 20 WAIT cycles; timeout_mask=4'b1100, fail_count=2, first_fail=2.
- Boundary: last test_done rises exactly in WAIT cycle 19 -> timeout_mask=0, all_pass=1.
- Reset mid-WAIT after 2 captures -> next cycle IDLE with every output 0. A following go_rise runs cleanly; stale masks are not visible.
- Re-run and sticky: in DONE, a go held high does not relaunch; go low then high relaunches and clears masks. Pulsing test_done[0] twice with dut_passed flipping to 0 on the second pulse leaves fail_mask[0]=0. With RESULT_COLLECTOR_PROTOCOL_CHECK_EN defined, that flip sets protocol_err=1.
